// File: rtl/oam_dma_arbiter.sv
// OAM DMA engine and CPU/bus arbiter: a write to DMA_REG copies DMA_LEN bytes from
// page XX00 into OAM while the CPU is confined to the 0xFFxx page; otherwise the bus is a pass-through.
`timescale 1ns/1ps
module oam_dma_arbiter #(
  parameter int          DMA_LEN  = 160,
  parameter int          PHASES   = 4,
  parameter logic [15:0] OAM_BASE = 16'hFE00,
  parameter logic [15:0] DMA_REG  = 16'hFF46
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_gnt,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;

  localparam logic [1:0] LAST_PH  = 2'(PHASES - 1);
  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  logic [1:0]  state;
  logic [7:0]  page_q;
  logic [7:0]  idx;
  logic [1:0]  phase;
  logic [7:0]  data_q;
  logic        rd_ff46_q;

  logic        is_reg;
  logic        trig;
  logic        hi_page;
  logic        busy;
  logic        dma_rd;
  logic        dma_wr;
  logic        mem_we_raw;
  logic [7:0]  src_hi;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;

  assign is_reg  = (cpu_addr == DMA_REG);
  assign trig    = cpu_req & cpu_we & is_reg;
  assign hi_page = (cpu_addr[15:8] == 8'hFF);
  assign busy    = (state != ST_IDLE);
  assign dma_rd  = (state == ST_XFER) && (phase == 2'd0);
  assign dma_wr  = (state == ST_XFER) && (phase == 2'd2);

  // Pages 0xE0-0xFF are echo RAM and fold back onto 0xC0-0xDF.
  assign src_hi   = (page_q < 8'hE0) ? page_q : (page_q - 8'h20);
  assign src_addr = {src_hi, idx};
  assign dst_addr = OAM_BASE + {8'h00, idx};

  // The DMA owns the bus on phases 0 and 2; the CPU may use the 0xFFxx page in
  // every other busy cycle. Trigger writes are always accepted but never reach the bus.
  always_comb begin
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    mem_we_raw = 1'b0;
    cpu_gnt    = 1'b0;
    if (dma_rd) begin
      mem_addr = src_addr;
      cpu_gnt  = trig;
    end else if (dma_wr) begin
      mem_addr   = dst_addr;
      mem_wdata  = data_q;
      mem_we_raw = 1'b1;
      cpu_gnt    = trig;
    end else if (!busy || hi_page) begin
      cpu_gnt    = cpu_req;
      mem_we_raw = cpu_req & cpu_we & ~is_reg;
    end
  end

  assign mem_we     = mem_we_raw & rst;
  assign dma_active = busy & rst;
  assign cpu_rdata  = rd_ff46_q ? page_q : mem_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      page_q    <= 8'h00;
      idx       <= 8'h00;
      phase     <= 2'd0;
      data_q    <= 8'h00;
      rd_ff46_q <= 1'b0;
    end else begin
      rd_ff46_q <= cpu_gnt & ~cpu_we & is_reg;
      // A new trigger takes priority over everything, including the final phase.
      if (trig) begin
        page_q <= cpu_wdata;
        state  <= ST_START;
        phase  <= 2'd0;
        idx    <= 8'h00;
      end else begin
        case (state)
          ST_START: begin
            if (phase == LAST_PH) begin
              state <= ST_XFER;
              phase <= 2'd0;
            end else begin
              phase <= phase + 2'd1;
            end
          end
          ST_XFER: begin
            if (phase == 2'd1) begin
              data_q <= mem_rdata;
            end
            if (phase == LAST_PH) begin
              phase <= 2'd0;
              if (idx == LAST_IDX) begin
                state <= ST_IDLE;
              end else begin
                idx <= idx + 8'd1;
              end
            end else begin
              phase <= phase + 2'd1;
            end
          end
          default: begin
            state <= ST_IDLE;
            phase <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Scoreboard bench for oam_dma_arbiter: directed CPU traffic queues expected read data
// and OAM writes; a negedge monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_oam_dma_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_gnt;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic        dma_active;

  logic [7:0]  mem [0:65535];
  int          cyc = 0;
  int          passes = 0;
  int          total = 0;
  int          oam_cnt = 0;
  logic        rd_pend = 1'b0;
  logic [7:0]  rd_q [$];
  logic [23:0] oam_q [$];

  oam_dma_arbiter dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata), .dma_active(dma_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Work RAM 0xC000-0xDFFF holds (low ^ 0xA5) + (page - 0xC0); 0xC000 starts at 0x5A.
  initial begin
    for (int a = 0; a < 65536; a++) begin
      logic [15:0] aa;
      aa = 16'(a);
      if (aa >= 16'hC000 && aa < 16'hE000) mem[a] = (aa[7:0] ^ 8'hA5) + (aa[15:8] - 8'hC0);
      else mem[a] = 8'h00;
    end
    mem[16'hC000] = 8'h5A;
    mem_rdata <= 8'h00;
    forever begin
      @(posedge clk);
      mem_rdata <= mem[mem_addr];
      if (mem_we) mem[mem_addr] = mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: read data one cycle after a granted read, and every OAM-range bus write.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_pend) begin
        if (rd_q.size() == 0) begin
          total++;
          $display("FAIL cpu_rdata: unexpected read data %0h", cpu_rdata);
        end else begin
          chk("cpu_rdata", {24'h0, cpu_rdata}, {24'h0, rd_q.pop_front()});
        end
      end
      rd_pend = rst & cpu_req & cpu_gnt & ~cpu_we;
      if (rst && mem_we && mem_addr >= 16'hFE00 && mem_addr < 16'hFEA0) begin
        oam_cnt++;
        if (oam_q.size() == 0) begin
          total++;
          $display("FAIL oam_write: unexpected write %0h <= %0h", mem_addr, mem_wdata);
        end else begin
          chk("oam_write", {8'h0, mem_addr, mem_wdata}, {8'h0, oam_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic push_oam(input int cnt, input logic [7:0] add);
    for (int i = 0; i < cnt; i++) begin
      logic [15:0] da;
      logic [7:0]  dv;
      da = 16'hFE00 + 16'(i);
      dv = (8'(i) ^ 8'hA5) + add;
      oam_q.push_back({da, dv});
    end
  endtask

  // Called at posedge+1; holds the request until granted, returns at posedge+1 after acceptance.
  task automatic access(input logic we, input logic [15:0] a, input logic [7:0] d, output int gcyc);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; gcyc = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (cpu_gnt) begin
        gcyc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
    if (gcyc < 0) begin
      total++;
      $display("FAIL access_timeout: addr %0h got %0d, expected a grant", a, gcyc);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic count_active(output int n);
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!dma_active) break;
      n++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int g, t, t1, n, n2;
    // Reset state with a pass-through write pending
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h8000; cpu_wdata = 8'h11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_dma_active", {31'h0, dma_active}, 32'h0);
    chk("rst_passthru_addr", {16'h0, mem_addr}, 32'h8000);
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0; rst = 1'b1;

    rd_q.push_back(8'h00);
    access(1'b0, 16'hFF46, 8'h00, g);

    // Idle pass-through read and write
    rd_q.push_back(8'h5A);
    t = cyc;
    access(1'b0, 16'hC000, 8'h00, g);
    chk("idle_read_gnt_cycle", g, t);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h8000; cpu_wdata = 8'h33;
    @(negedge clk);
    chk("idle_write_gnt", {31'h0, cpu_gnt}, 32'h1);
    chk("idle_write_we", {31'h0, mem_we}, 32'h1);
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    chk("idle_write_we_drop", {31'h0, mem_we}, 32'h0);
    @(posedge clk); #1;
    chk("idle_write_mem", {24'h0, mem[16'h8000]}, 32'h33);
    access(1'b1, 16'hC000, 8'hA5, g);

    // Full DMA from page 0xC0
    push_oam(160, 8'h00);
    n = oam_cnt;
    access(1'b1, 16'hFF46, 8'hC0, g);
    count_active(n2);
    chk("full_dma_active_len", n2, 644);
    chk("full_oam_pulses", oam_cnt - n, 160);
    chk("full_oam_fe00", {24'h0, mem[16'hFE00]}, 32'hA5);
    chk("full_oam_fe9f", {24'h0, mem[16'hFE9F]}, 32'h3A);

    // Stall and HRAM access during a copy
    push_oam(160, 8'h00);
    access(1'b1, 16'hFF46, 8'hC0, g);
    t = cyc;
    wait_cyc(t + 10);
    access(1'b1, 16'hFF90, 8'h77, g);
    chk("hram_write_gnt_cycle", g, t + 11);
    rd_q.push_back(8'h77);
    access(1'b0, 16'hFF90, 8'h00, g);
    chk("hram_read_gnt_cycle", g, t + 13);
    rd_q.push_back(8'h87);
    access(1'b0, 16'hC123, 8'h00, g);
    chk("stall_gnt_cycle", g, t + 644);
    chk("stall_oam_fe50", {24'h0, mem[16'hFE50]}, 32'hF5);

    // Echo-mapped page 0xE1 reads from 0xC100, and the register reads back
    push_oam(160, 8'h01);
    access(1'b1, 16'hFF46, 8'hE1, g);
    count_active(n2);
    chk("echo_active_len", n2, 644);
    rd_q.push_back(8'hE1);
    access(1'b0, 16'hFF46, 8'h00, g);
    chk("echo_oam_fe00", {24'h0, mem[16'hFE00]}, 32'hA6);

    // Restart at clock 300 with page 0xD0
    push_oam(74, 8'h00);
    access(1'b1, 16'hFF46, 8'hC0, g);
    t1 = cyc;
    wait_cyc(t1 + 299);
    access(1'b1, 16'hFF46, 8'hD0, g);
    chk("restart_gnt_cycle", g, t1 + 299);
    push_oam(160, 8'h10);
    count_active(n2);
    chk("restart_active_len", n2, 644);
    chk("restart_oam_fe00", {24'h0, mem[16'hFE00]}, 32'hB5);
    chk("restart_oam_fe49", {24'h0, mem[16'hFE49]}, 32'hFC);
    chk("restart_oam_fe9f", {24'h0, mem[16'hFE9F]}, 32'h4A);
    chk("restart_queue_empty", oam_q.size(), 0);

    // Reset asserted for one cycle at clock 200 of a copy
    push_oam(49, 8'h00);
    n = oam_cnt;
    access(1'b1, 16'hFF46, 8'hC0, g);
    t = cyc;
    wait_cyc(t + 200);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_dma_active_low", {31'h0, dma_active}, 32'h0);
    chk("midrst_mem_we_low", {31'h0, mem_we}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("postrst_dma_active", {31'h0, dma_active}, 32'h0);
    chk("postrst_mem_we", {31'h0, mem_we}, 32'h0);
    repeat (20) @(negedge clk);
    chk("postrst_oam_writes", oam_cnt - n, 49);
    chk("postrst_oam_fe00", {24'h0, mem[16'hFE00]}, 32'hA5);
    chk("postrst_oam_fe31", {24'h0, mem[16'hFE31]}, 32'hA4);
    @(posedge clk); #1;
    rd_q.push_back(8'h00);
    access(1'b0, 16'hFF46, 8'h00, g);

    repeat (3) @(posedge clk);
    #1;
    chk("final_rd_queue_empty", rd_q.size(), 0);
    chk("final_oam_queue_empty", oam_q.size(), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
